uc_arbiter: RTL and testbench

UC_ARBITER -- requirements
Module: uc_arbiter

---
 rtl/uc_arbiter.sv | 154 +++++++++++++++
 tb/tb_uc_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin pop from per-PE input queues, broadcast of new literals to all PEs.
// Define UCARB_DEDUP_EN to add the assignment table (duplicate drop and conflict detection).
module uc_arbiter #(
  parameter int NUM_PE   = 4,
  parameter int LIT_W    = 16,
  parameter int NUM_VARS = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uc_clear,
  input  logic [NUM_PE-1:0]       ucq_in_empty,
  input  logic [NUM_PE*LIT_W-1:0] ucq_in_uc,
  output logic [NUM_PE-1:0]       ucq_in_pop,
  input  logic [NUM_PE-1:0]       ucq_out_full,
  output logic [NUM_PE-1:0]       ucq_out_push,
  output logic [LIT_W-1:0]        ucq_out_uc,
  output logic                    conflict,
  output logic                    busy
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int VAR_W = $clog2(NUM_VARS + 1);
  localparam logic [LIT_W-1:0] MAX_VAR = LIT_W'(NUM_VARS);

  typedef enum logic [1:0] {IDLE, CHECK, CONFLICT} state_t;

  state_t            state, state_d;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_d;
  logic [LIT_W-1:0]  hold_lit, sel_lit;
  logic [NUM_PE-1:0] pop_d;
  logic              init_done, active, found, load, push_all;
  int                sel_idx;

  logic              lit_neg, lit_valid;
  logic [LIT_W-1:0]  lit_mag;

  assign lit_neg   = hold_lit[LIT_W-1];
  assign lit_mag   = lit_neg ? (~hold_lit + LIT_W'(1)) : hold_lit;
  assign lit_valid = (lit_mag != '0) && (lit_mag <= MAX_VAR);

  // init_done keeps pops off for the first cycle after reset is released
  assign active = rst_n && init_done && !uc_clear;

`ifdef UCARB_DEDUP_EN
  logic [(1<<VAR_W)-1:0] var_set, var_pol;
  logic [VAR_W-1:0]      var_idx;
  logic                  conflict_q, hit, hit_pol, record, conflict_set;

  assign var_idx = lit_mag[VAR_W-1:0];
  assign hit     = var_set[var_idx];
  assign hit_pol = var_pol[var_idx];
`endif

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    pop_d    = '0;
    load     = 1'b0;
    push_all = 1'b0;
    found    = 1'b0;
    sel_idx  = 0;
`ifdef UCARB_DEDUP_EN
    record       = 1'b0;
    conflict_set = 1'b0;
`endif
    for (int i = 0; i < NUM_PE; i++) begin
      if (!found && !ucq_in_empty[(int'(rr_ptr) + i) % NUM_PE]) begin
        found   = 1'b1;
        sel_idx = (int'(rr_ptr) + i) % NUM_PE;
      end
    end
    sel_lit = ucq_in_uc[sel_idx*LIT_W +: LIT_W];

    case (state)
      IDLE: begin
        if (active && found) begin
          pop_d[sel_idx] = 1'b1;
          load           = 1'b1;
          rr_ptr_d       = (sel_idx == NUM_PE - 1) ? '0 : PTR_W'(sel_idx + 1);
          state_d        = CHECK;
        end
      end
      CHECK: begin
        if (active) begin
          if (!lit_valid) begin
            state_d = IDLE;
          end
`ifdef UCARB_DEDUP_EN
          else if (hit && (hit_pol == lit_neg)) begin
            state_d = IDLE;
          end
          else if (hit) begin
            conflict_set = 1'b1;
            state_d      = CONFLICT;
          end
`endif
          else if (ucq_out_full == '0) begin
            push_all = 1'b1;
`ifdef UCARB_DEDUP_EN
            record   = 1'b1;
`endif
            state_d  = IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      hold_lit  <= '0;
      init_done <= 1'b0;
    end else if (uc_clear) begin
      state     <= IDLE;
      hold_lit  <= '0;
      init_done <= 1'b1;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      init_done <= 1'b1;
      if (load) hold_lit <= sel_lit;
    end
  end

`ifdef UCARB_DEDUP_EN
  // Table only changes when a literal is actually broadcast
  always_ff @(posedge clk) begin
    if (!rst_n || uc_clear) begin
      var_set    <= '0;
      var_pol    <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (record) begin
        var_set[var_idx] <= 1'b1;
        var_pol[var_idx] <= lit_neg;
      end
      if (conflict_set) conflict_q <= 1'b1;
    end
  end

  assign conflict = conflict_q;
`else
  assign conflict = 1'b0;
`endif

  assign ucq_in_pop   = pop_d;
  assign ucq_out_push = {NUM_PE{push_all}};
  assign ucq_out_uc   = push_all ? hold_lit : '0;
  assign busy         = rst_n && (state == CHECK);

endmodule

// File: tb/tb_uc_arbiter.sv
// Self-checking bench for uc_arbiter: PE queue model, broadcast scoreboard, vector table and corner sequences.
// Expectations follow UCARB_DEDUP_EN in the same way as the design.
module tb_uc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, uc_clear;
  logic [3:0]  ucq_in_empty, ucq_in_pop, ucq_out_full, ucq_out_push;
  logic [63:0] ucq_in_uc;
  logic [15:0] ucq_out_uc;
  logic        conflict, busy;

  always #5 clk = ~clk;

  uc_arbiter #(.NUM_PE(4), .LIT_W(16), .NUM_VARS(255)) dut (
    .clk(clk), .rst_n(rst_n), .uc_clear(uc_clear),
    .ucq_in_empty(ucq_in_empty), .ucq_in_uc(ucq_in_uc), .ucq_in_pop(ucq_in_pop),
    .ucq_out_full(ucq_out_full), .ucq_out_push(ucq_out_push), .ucq_out_uc(ucq_out_uc),
    .conflict(conflict), .busy(busy)
  );

  typedef struct {
    int          pe;
    logic [15:0] lit;
    logic        exp_bcast;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] pe_q[4][$];
  logic [15:0] exp_q[$];
  int          pop_log[$];
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  int          last_pop_cyc = 0, last_push_cyc = 0, push_count = 0, pop_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: got %0h, expected no such event", name, act);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int firstBit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refreshInputs();
    for (int i = 0; i < 4; i++) begin
      ucq_in_empty[i]        = (pe_q[i].size() == 0);
      ucq_in_uc[i*16 +: 16]  = (pe_q[i].size() == 0) ? 16'h0 : pe_q[i][0];
    end
  endtask

  // PE queue model and scoreboard: observe at negedge, retire pops just after posedge
  initial begin
    logic [3:0] pop_seen;
    refreshInputs();
    forever begin
      @(negedge clk);
      cyc++;
      pop_seen = ucq_in_pop;
      if (ucq_out_full != 4'b0) checkOutput("push_while_full", ucq_out_push, 4'b0);
      if (ucq_out_push != 4'b0) begin
        push_count++;
        last_push_cyc = cyc;
        checkOutput("push_all", ucq_out_push, 4'hF);
        if (exp_q.size() == 0) reportFail("unexpected_push", ucq_out_uc);
        else checkOutput("push_uc", ucq_out_uc, exp_q.pop_front());
      end
      if (pop_seen != 4'b0) begin
        pop_count++;
        last_pop_cyc = cyc;
        pop_log.push_back(firstBit(pop_seen));
        checkOutput("pop_onehot", $onehot(pop_seen), 1);
        checkOutput("pop_not_busy", busy, 0);
        checkOutput("pop_nonempty", ucq_in_empty & pop_seen, 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (pop_seen[i] && pe_q[i].size() > 0) void'(pe_q[i].pop_front());
      refreshInputs();
    end
  end

  task automatic waitDrain(input string name);
    bit done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (pe_q[0].size() == 0 && pe_q[1].size() == 0 && pe_q[2].size() == 0 &&
          pe_q[3].size() == 0 && exp_q.size() == 0 && !busy)
        done = 1;
    end
    if (!done) reportFail(name, exp_q.size());
  endtask

  task automatic applyStimulus(input vec_t v);
    int pc0, pu0;
    pc0 = pop_count;
    pu0 = push_count;
    pe_q[v.pe].push_back(v.lit);
    if (v.exp_bcast) exp_q.push_back(v.lit);
    waitDrain("vec_drain");
    checkOutput("vec_pops", pop_count - pc0, 1);
    checkOutput("vec_pushes", push_count - pu0, {31'b0, v.exp_bcast});
    if (v.exp_bcast) checkOutput("vec_latency", last_push_cyc - last_pop_cyc, 1);
    checkOutput("vec_conflict", conflict, 0);
  endtask

  initial begin
    vec_t v;
    int   pu0, pc0;
    bit   got;
    rst_n        = 1'b0;
    uc_clear     = 1'b0;
    ucq_out_full = 4'b0;
    vecs[0] = '{2, 16'd5,    1'b1};
    vecs[1] = '{1, 16'd0,    1'b0};
    vecs[2] = '{0, 16'd256,  1'b0};
    vecs[3] = '{3, 16'hFF00, 1'b0};
    vecs[4] = '{1, 16'h8000, 1'b0};
    vecs[5] = '{3, 16'd255,  1'b1};
    vecs[6] = '{0, 16'hFFFF, 1'b1};
    vecs[7] = '{2, 16'd17,   1'b1};

    // Reset with a literal already waiting: nothing may move until reset has settled
    pe_q[3].push_back(16'd11);
    exp_q.push_back(16'd11);
    repeat (2) begin
      tick();
      checkOutput("rst_pop", ucq_in_pop, 0);
      checkOutput("rst_push", ucq_out_push, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_uc", ucq_out_uc, 0);
      checkOutput("rst_conflict", conflict, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_pop", ucq_in_pop, 0);
    checkOutput("post_rst_push", ucq_out_push, 0);
    checkOutput("post_rst_busy", busy, 0);
    waitDrain("rst_drain");

    // Two PEs at once with rr_ptr back at 0
    pop_log.delete();
    pe_q[0].push_back(16'd3);
    pe_q[1].push_back(16'hFFF9);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'hFFF9);
    waitDrain("rr_drain");
    checkOutput("rr_pop_count", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      checkOutput("rr_first", pop_log[0], 0);
      checkOutput("rr_second", pop_log[1], 1);
    end

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Output stall for five cycles
    @(posedge clk);
    #1;
    ucq_out_full = 4'b1000;
    pe_q[0].push_back(16'd4);
    exp_q.push_back(16'd4);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (busy) got = 1;
    end
    if (!got) reportFail("stall_busy_timeout", busy);
    else begin
      for (int c = 0; c < 5; c++) begin
        if (c > 0) tick();
        checkOutput("stall_busy", busy, 1);
        checkOutput("stall_push", ucq_out_push, 0);
      end
      @(posedge clk);
      #1;
      ucq_out_full = 4'b0;
      tick();
      checkOutput("stall_release_push", ucq_out_push, 4'hF);
    end
    waitDrain("stall_drain");

`ifdef UCARB_DEDUP_EN
    v = '{1, 16'd9, 1'b1};
    applyStimulus(v);
    v = '{2, 16'd9, 1'b0};
    applyStimulus(v);
    pu0 = push_count;
    pe_q[3].push_back(16'hFFF7);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (conflict) got = 1;
    end
    checkOutput("conflict_set", conflict, 1);
    checkOutput("conflict_no_push", push_count - pu0, 0);
    checkOutput("conflict_not_busy", busy, 0);
    pc0 = pop_count;
    pe_q[0].push_back(16'd9);
    pe_q[1].push_back(16'd21);
    exp_q.push_back(16'd9);
    exp_q.push_back(16'd21);
    repeat (4) begin
      tick();
      checkOutput("conflict_pop", ucq_in_pop, 0);
      checkOutput("conflict_sticky", conflict, 1);
    end
    checkOutput("conflict_pop_count", pop_count - pc0, 0);
    pop_log.delete();
    @(posedge clk);
    #1;
    uc_clear = 1'b1;
    tick();
    checkOutput("clear_cycle_pop", ucq_in_pop, 0);
    checkOutput("clear_cycle_push", ucq_out_push, 0);
    @(posedge clk);
    #1;
    uc_clear = 1'b0;
    tick();
    checkOutput("clear_conflict", conflict, 0);
    waitDrain("clear_drain");
    if (pop_log.size() > 0) checkOutput("clear_rr_first", pop_log[0], 0);
    checkOutput("clear_conflict_after", conflict, 0);
`else
    v = '{1, 16'd9, 1'b1};
    applyStimulus(v);
    v = '{2, 16'hFFF7, 1'b1};
    applyStimulus(v);
    v = '{3, 16'd9, 1'b1};
    applyStimulus(v);
`endif

    // Reset while a literal is held behind a full output queue
    @(posedge clk);
    #1;
    ucq_out_full = 4'b0010;
    pe_q[2].push_back(16'd13);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (busy) got = 1;
    end
    if (!got) reportFail("rst_hold_timeout", busy);
    pu0 = push_count;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    tick();
    checkOutput("rst_hold_busy", busy, 0);
    checkOutput("rst_hold_push", ucq_out_push, 0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    ucq_out_full = 4'b0;
    repeat (4) tick();
    checkOutput("rst_discard_push", push_count - pu0, 0);
    checkOutput("rst_discard_busy", busy, 0);
    v = '{0, 16'hFFF7, 1'b1};
    applyStimulus(v);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
